// File: rtl/sb_fifo.sv
// sb_fifo: first-word-fall-through FIFO between the stream source and sink.
// It holds up to DEPTH words. The head word is read combinationally from the
// storage array. The ready, valid and almost-full outputs are registered
// forms of the next occupancy, so each takes effect one edge after the
// transfer that changes it.
module sb_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [DATA_W-1:0]          s_data_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [DATA_W-1:0]          m_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       almost_full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         s_ready_q, s_ready_d;
    logic                         m_valid_q, m_valid_d;
    logic                         afull_q, afull_d;
    logic                         push, pop;

    // A transfer happens only when both sides agree in the same cycle.
    // Words offered while s_ready_o is low are dropped on the floor.
    assign push = s_valid_i & s_ready_q;
    assign pop  = m_valid_q & m_ready_i;

    // Compute the next pointer, occupancy and flag state from this cycle's transfers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Flags are derived from the next count. A pop from full frees space
        // and a push into empty shows the word, each one edge later.
        s_ready_d = (count_d != FULL_CNT);
        m_valid_d = (count_d != '0);
        afull_d   = (count_d >= AFULL_CNT);
    end

    // Pointer, count and flag registers. s_ready_q resets low and comes up
    // on the first edge after reset is released.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            afull_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            afull_q   <= afull_d;
        end
    end

    // Storage array. It is cleared on reset so the head output reads 0 while the FIFO is empty after reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mem_q <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

    assign s_ready_o     = s_ready_q;
    assign m_valid_o     = m_valid_q;
    assign m_data_o      = mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign almost_full_o = afull_q;

endmodule
